// File: rtl/vid_pkg.sv
// rtl/vid_pkg.sv - display geometry constants, fetch FSM states and count-width helper
package vid_pkg;

    localparam int          H_WORDS = 32;
    localparam int          V_LINES = 768;
    localparam logic [17:0] FB_ORG  = 18'h37FC0;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DRAIN
    } fetch_state_e;

    // bits needed to hold a count from 0 to n inclusive
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/vid_fifo.sv
// rtl/vid_fifo.sv - single-clock first-word-fall-through FIFO with flush; head holds last popped word when empty
import vid_pkg::*;

module vid_fifo #(
    parameter int DEPTH = 32,
    parameter int W     = 32,
    parameter int CW    = cnt_w(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [W-1:0]  last_q, last_d;
    logic          do_push, do_pop;

    assign empty   = (count_q == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & ((count_q != CW'(DEPTH)) | do_pop);
    assign head    = empty ? last_q : mem[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        last_d   = last_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
                last_d   = mem[rd_ptr_q];
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            last_q   <= last_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/vid_fetch.sv
// rtl/vid_fetch.sv - burst prefetcher feeding display words bottom-up from SDRAM; VID_FETCH_STATS_EN adds underrun_cnt and fill_min
import vid_pkg::*;

module vid_fetch #(
    parameter logic [17:0] FRAME_BASE = FB_ORG,
    parameter int          LINE_WORDS = H_WORDS,
    parameter int          LINES      = V_LINES,
    parameter int          BURST_LEN  = 8,
    parameter int          DEPTH      = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        frame_start,
    input  logic        req,
    output logic [31:0] viddata,
    output logic        mem_rd,
    output logic [17:0] mem_addr,
    input  logic        mem_ack,
    input  logic        mem_valid,
    input  logic [31:0] mem_data,
`ifdef VID_FETCH_STATS_EN
    output logic [15:0] underrun_cnt,
    output logic [5:0]  fill_min,
`endif
    output logic        underrun
);

    localparam int CW = cnt_w(DEPTH);
    localparam int FW = cnt_w(BURST_LEN);
    localparam int WW = $clog2(LINE_WORDS);
    localparam int LW = cnt_w(LINES);

    fetch_state_e  state_q, state_d;
    logic [FW-1:0] in_flight_q, in_flight_d;
    logic [WW-1:0] word_q, word_d;
    logic [LW-1:0] line_q, line_d;
    logic          mem_rd_q, mem_rd_d;
    logic          underrun_q, underrun_d;
    logic [CW-1:0] fifo_count;
    logic          fifo_empty;
    logic          empty_req, pop, push, beat, exhausted, room;
    logic [17:0]   line_off;

    assign empty_req = req & ce & fifo_empty;
    assign pop       = req & ce & ~fifo_empty;
    // a beat with nothing outstanding is a protocol error and is ignored
    assign beat      = mem_valid & (in_flight_q != '0) & ((state_q == WAIT) | (state_q == DRAIN));
    assign push      = beat & (state_q == WAIT) & ~frame_start;
    assign exhausted = (line_q == LW'(LINES));
    assign room      = (32'(fifo_count) + 32'(in_flight_q)) <= 32'(DEPTH - BURST_LEN);
    assign line_off  = 18'(32'(line_q) * 32'(LINE_WORDS));
    assign mem_addr  = FRAME_BASE - line_off + 18'(word_q);
    assign mem_rd    = mem_rd_q;
    assign underrun  = underrun_q;

    vid_fifo #(
        .DEPTH (DEPTH),
        .W     (32)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (frame_start),
        .push  (push),
        .wdata (mem_data),
        .pop   (pop),
        .head  (viddata),
        .count (fifo_count),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        in_flight_d = in_flight_q;
        word_d      = word_q;
        line_d      = line_q;
        mem_rd_d    = mem_rd_q;
        underrun_d  = underrun_q | empty_req;
        if (beat) begin
            in_flight_d = in_flight_q - FW'(1);
        end
        unique case (state_q)
            IDLE: begin
                if (room && !exhausted) begin
                    state_d  = ISSUE;
                    mem_rd_d = 1'b1;
                end
            end
            ISSUE: begin
                if (mem_ack) begin
                    state_d     = WAIT;
                    mem_rd_d    = 1'b0;
                    in_flight_d = in_flight_q + FW'(BURST_LEN);
                    word_d      = word_q + WW'(BURST_LEN);
                    if (word_d == '0) begin
                        line_d = line_q + LW'(1);
                    end
                end
            end
            WAIT, DRAIN: begin
                if (in_flight_d == '0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // an ack coinciding with frame_start is still outstanding and must be drained
        if (frame_start) begin
            word_d   = '0;
            line_d   = '0;
            mem_rd_d = 1'b0;
            state_d  = (in_flight_d != '0) ? DRAIN : IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            in_flight_q <= '0;
            word_q      <= '0;
            line_q      <= '0;
            mem_rd_q    <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_flight_q <= in_flight_d;
            word_q      <= word_d;
            line_q      <= line_d;
            mem_rd_q    <= mem_rd_d;
            underrun_q  <= underrun_d;
        end
    end

`ifdef VID_FETCH_STATS_EN
    logic [15:0] underrun_cnt_q, underrun_cnt_d;
    logic [5:0]  fill_min_q, fill_min_d;

    assign underrun_cnt = underrun_cnt_q;
    assign fill_min     = fill_min_q;

    always_comb begin
        underrun_cnt_d = underrun_cnt_q;
        fill_min_d     = fill_min_q;
        if (frame_start) begin
            underrun_cnt_d = '0;
            fill_min_d     = '1;
        end else begin
            if (empty_req && (underrun_cnt_q != '1)) begin
                underrun_cnt_d = underrun_cnt_q + 16'd1;
            end
            if (6'(fifo_count) < fill_min_q) begin
                fill_min_d = 6'(fifo_count);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            underrun_cnt_q <= '0;
            fill_min_q     <= '1;
        end else begin
            underrun_cnt_q <= underrun_cnt_d;
            fill_min_q     <= fill_min_d;
        end
    end
`endif

endmodule
